// File: rtl/approx_add_pkg.sv
//------------------------------------------------------------------------------
// Module   : approx_add_pkg
// Brief    : Shared constants and approximate-sum reference function.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package approx_add_pkg;

    localparam int unsigned        c_CNT_W   = 32;
    localparam logic [c_CNT_W-1:0] c_CNT_SAT = '1;

    // Arithmetic model of the adder: width and approx bit count are runtime
    // arguments so one function serves every parameterisation (width <= 32).
    function automatic logic [32:0] approx_sum_ref(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned width,
        input int unsigned k,
        input logic        approx_en
    );
        logic [32:0] mask_w;
        logic [32:0] mask_k;
        logic [32:0] aa;
        logic [32:0] bb;
        logic [32:0] lo;
        logic [32:0] hi;
        logic        cin;
        mask_w = (33'd1 << width) - 33'd1;
        aa     = {1'b0, a} & mask_w;
        bb     = {1'b0, b} & mask_w;
        if (!approx_en || k == 0) begin
            return aa + bb;
        end
        mask_k = (33'd1 << k) - 33'd1;
        lo     = (aa | bb) & mask_k;
        cin    = aa[k-1] & bb[k-1];
        hi     = (aa >> k) + (bb >> k) + {32'd0, cin};
        return (hi << k) | lo;
    endfunction

endpackage

`default_nettype wire

// File: rtl/approx_add_core.sv
//------------------------------------------------------------------------------
// Module   : approx_add_core
// Brief    : Combinational lower-part-OR adder with exact sum alongside.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module approx_add_core #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             approx_en,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   exact_sum
);

    logic [WIDTH:0] w_approx;

    assign exact_sum = {1'b0, a} + {1'b0, b};

    generate
        if (APPROX_BITS == 0) begin : g_exact_only
            assign w_approx = exact_sum;
        end else if (APPROX_BITS == WIDTH) begin : g_all_or
            // No exact upper part remains; the speculated carry is the carry-out.
            assign w_approx = {a[WIDTH-1] & b[WIDTH-1], a | b};
        end else begin : g_split
            logic                         w_cin;
            logic [WIDTH-APPROX_BITS:0]   w_hi;
            assign w_cin    = a[APPROX_BITS-1] & b[APPROX_BITS-1];
            assign w_hi     = {1'b0, a[WIDTH-1:APPROX_BITS]}
                            + {1'b0, b[WIDTH-1:APPROX_BITS]}
                            + {{(WIDTH-APPROX_BITS){1'b0}}, w_cin};
            assign w_approx = {w_hi, a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0]};
        end
    endgenerate

    assign sum = approx_en ? w_approx : exact_sum;

endmodule

`default_nettype wire

// File: rtl/approx_add_pipe.sv
//------------------------------------------------------------------------------
// Module   : approx_add_pipe
// Brief    : Two-stage elastic approximate/exact adder; optional error monitor
//            compiled in with macro APPROX_ADD_ERR_MON_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               approx_en_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH:0]     sum_o,
    input  logic               err_clr_i,
    output logic [WIDTH:0]     err_max_o,
    output logic [c_CNT_W-1:0] err_sum_o,
    output logic [c_CNT_W-1:0] err_cnt_o
);

    logic               r_s1_full;
    logic               r_s1_mode;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic               r_s2_full;
    logic [WIDTH:0]     r_s2_sum;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_exact;
    logic               w_s2_adv;
    logic               w_out_hs;

    // S2 can take a new value when empty or when its result leaves this cycle.
    assign w_s2_adv    = !r_s2_full || out_ready_i;
    assign in_ready_o  = !r_s1_full || w_s2_adv;
    assign w_out_hs    = r_s2_full && out_ready_i;
    assign out_valid_o = r_s2_full;
    assign sum_o       = r_s2_sum;

    approx_add_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .a         (r_s1_a),
        .b         (r_s1_b),
        .approx_en (r_s1_mode),
        .sum       (w_sum),
        .exact_sum (w_exact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_full <= 1'b0;
            r_s1_mode <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s2_full <= 1'b0;
            r_s2_sum  <= '0;
        end else begin
            if (in_ready_o) begin
                r_s1_full <= in_valid_i;
                if (in_valid_i) begin
                    r_s1_a    <= a_i;
                    r_s1_b    <= b_i;
                    r_s1_mode <= approx_en_i;
                end
            end
            if (w_s2_adv) begin
                r_s2_full <= r_s1_full;
                if (r_s1_full) begin
                    r_s2_sum <= w_sum;
                end
            end
        end
    end

`ifdef APPROX_ADD_ERR_MON_EN
    logic [WIDTH:0]     r_s2_exact;
    logic [WIDTH:0]     r_err_max;
    logic [c_CNT_W-1:0] r_err_sum;
    logic [c_CNT_W-1:0] r_err_cnt;

    logic [WIDTH:0]     w_err;
    logic [WIDTH:0]     w_max_base;
    logic [WIDTH:0]     w_max_next;
    logic [c_CNT_W-1:0] w_sum_base;
    logic [c_CNT_W-1:0] w_cnt_base;
    logic [c_CNT_W+1:0] w_acc;
    logic [c_CNT_W-1:0] w_sum_next;
    logic [c_CNT_W-1:0] w_cnt_next;

    assign w_err = (r_s2_exact >= r_s2_sum) ? (r_s2_exact - r_s2_sum)
                                            : (r_s2_sum - r_s2_exact);

    // A clear coincident with a handshake restarts from this result alone.
    assign w_max_base = err_clr_i ? '0 : r_err_max;
    assign w_sum_base = err_clr_i ? '0 : r_err_sum;
    assign w_cnt_base = err_clr_i ? '0 : r_err_cnt;

    assign w_max_next = (w_err > w_max_base) ? w_err : w_max_base;
    assign w_acc      = {2'b00, w_sum_base} + {{(c_CNT_W+1-WIDTH){1'b0}}, w_err};
    assign w_sum_next = (w_acc > {2'b00, c_CNT_SAT}) ? c_CNT_SAT : w_acc[c_CNT_W-1:0];
    assign w_cnt_next = (w_cnt_base == c_CNT_SAT) ? c_CNT_SAT : w_cnt_base + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_exact <= '0;
            r_err_max  <= '0;
            r_err_sum  <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_s2_adv && r_s1_full) begin
                r_s2_exact <= w_exact;
            end
            if (w_out_hs) begin
                r_err_max <= w_max_next;
                r_err_sum <= w_sum_next;
                r_err_cnt <= w_cnt_next;
            end else if (err_clr_i) begin
                r_err_max <= '0;
                r_err_sum <= '0;
                r_err_cnt <= '0;
            end
        end
    end

    assign err_max_o = r_err_max;
    assign err_sum_o = r_err_sum;
    assign err_cnt_o = r_err_cnt;
`else
    logic w_unused_mon;
    assign w_unused_mon = ^{w_exact, err_clr_i, w_out_hs};

    assign err_max_o = '0;
    assign err_sum_o = '0;
    assign err_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_approx_add_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_approx_add_pipe
// Brief    : Self-checking bench for approx_add_pipe (WIDTH=8, APPROX_BITS=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_approx_add_pipe;
    import approx_add_pkg::*;

    localparam int W = 8;
    localparam int K = 4;
`ifdef APPROX_ADD_ERR_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          approx_en_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W:0]    sum_o;
    logic          err_clr_i;
    logic [W:0]    err_max_o;
    logic [31:0]   err_sum_o;
    logic [31:0]   err_cnt_o;

    approx_add_pipe #(.WIDTH(W), .APPROX_BITS(K)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .approx_en_i (approx_en_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .err_clr_i   (err_clr_i),
        .err_max_o   (err_max_o),
        .err_sum_o   (err_sum_o),
        .err_cnt_o   (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W:0] sum;
        logic [W:0] exact;
    } exp_t;

    exp_t   q[$];
    int     total = 0;
    int     bad   = 0;
    longint m_max = 0;
    longint m_sum = 0;
    longint m_cnt = 0;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic m);
        logic [32:0] r;
        r = approx_sum_ref(32'(a), 32'(b), W, K, m);
        return r[W:0];
    endfunction

    function automatic logic [W:0] exp_max();
        return MON ? (W+1)'(m_max) : '0;
    endfunction

    function automatic logic [31:0] exp_esum();
        return MON ? 32'(m_sum) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_ecnt();
        return MON ? 32'(m_cnt) : 32'd0;
    endfunction

    task automatic push_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t e;
        e.sum   = ref_sum(a, b, m);
        e.exact = {1'b0, a} + {1'b0, b};
        q.push_back(e);
    endtask

    task automatic model_account(input exp_t e, input logic clr);
        longint err;
        err = (e.exact > e.sum) ? longint'(e.exact) - longint'(e.sum)
                                : longint'(e.sum) - longint'(e.exact);
        if (clr) begin
            m_max = 0;
            m_sum = 0;
            m_cnt = 0;
        end
        if (err > m_max) m_max = err;
        m_sum = (m_sum + err > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sum + err;
        m_cnt = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
    endtask

    task automatic model_clear();
        m_max = 0;
        m_sum = 0;
        m_cnt = 0;
    endtask

    // Drive one cycle's inputs just after the edge, return at the falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input logic ordy, input logic clr, input logic r);
        @(posedge clk);
        #1;
        rst         = r;
        in_valid_i  = v;
        a_i         = a;
        b_i         = b;
        approx_en_i = m;
        out_ready_i = ordy;
        err_clr_i   = clr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        q.delete();
        model_clear();
        total += 6;
        if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
        if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        if (sum_o !== '0) begin bad++; $display("FAIL reset_sum: got %h want 000", sum_o); end
        if (err_max_o !== '0) begin bad++; $display("FAIL reset_err_max: got %h want 0", err_max_o); end
        if (err_sum_o !== '0) begin bad++; $display("FAIL reset_err_sum: got %h want 0", err_sum_o); end
        if (err_cnt_o !== '0) begin bad++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt_o); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4] = '{8'h0F, 8'h0F, 8'hFF, 8'hFF};
        logic [W-1:0] tb[4] = '{8'h01, 8'h01, 8'hFF, 8'hFF};
        logic         tm[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [W:0]   te[4] = '{9'h00F, 9'h010, 9'h1FF, 9'h1FE};
        exp_t         e;
        for (int i = 0; i < 4; i++) begin
            cycle(1, ta[i], tb[i], tm[i], 1, 0, 0);
            total++;
            if (in_ready_o !== 1'b1) begin bad++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready_o); end
            push_beat(ta[i], tb[i], tm[i]);
            cycle(0, 0, 0, 0, 1, 0, 0);
            total++;
            if (out_valid_o !== 1'b0) begin bad++; $display("FAIL dir_early_valid[%0d]: got %b want 0", i, out_valid_o); end
            cycle(0, 0, 0, 0, 1, 0, 0);
            total += 2;
            if (out_valid_o !== 1'b1) begin bad++; $display("FAIL dir_valid[%0d]: got %b want 1", i, out_valid_o); end
            if (sum_o !== te[i]) begin bad++; $display("FAIL dir_sum[%0d]: got %h want %h", i, sum_o, te[i]); end
            e = q.pop_front();
            model_account(e, 1'b0);
            cycle(0, 0, 0, 0, 1, 0, 0);
            total += 3;
            if (err_max_o !== exp_max()) begin bad++; $display("FAIL dir_err_max[%0d]: got %h want %h", i, err_max_o, exp_max()); end
            if (err_sum_o !== exp_esum()) begin bad++; $display("FAIL dir_err_sum[%0d]: got %0d want %0d", i, err_sum_o, exp_esum()); end
            if (err_cnt_o !== exp_ecnt()) begin bad++; $display("FAIL dir_err_cnt[%0d]: got %0d want %0d", i, err_cnt_o, exp_ecnt()); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, stalls = 0, first = -1, last = -1;
        logic [W-1:0] a, b;
        logic m, v;
        exp_t e;
        cycle(0, 0, 0, 0, 1, 1, 0);
        model_clear();
        for (int c = 0; c < 110; c++) begin
            v = (sent < 100);
            a = W'($urandom);
            b = W'($urandom);
            m = 1'($urandom_range(0, 1));
            cycle(v, a, b, m, 1, 0, 0);
            if (v && in_ready_o) begin
                push_beat(a, b, m);
                sent++;
            end else if (v) begin
                stalls++;
            end
            if (out_valid_o) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL b2b_spurious: got result %h want none", sum_o);
                end else begin
                    e = q.pop_front();
                    if (sum_o !== e.sum) begin bad++; $display("FAIL b2b_sum[%0d]: got %h want %h", got, sum_o, e.sum); end
                    model_account(e, 1'b0);
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
        end
        total += 6;
        if (stalls != 0) begin bad++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
        if (got != 100) begin bad++; $display("FAIL b2b_count: got %0d want 100", got); end
        if (last - first != 99) begin bad++; $display("FAIL b2b_rate: got span %0d want 99", last - first); end
        if (err_cnt_o !== (MON ? 32'd100 : 32'd0)) begin bad++; $display("FAIL b2b_err_cnt: got %0d want %0d", err_cnt_o, MON ? 100 : 0); end
        if (err_sum_o !== exp_esum()) begin bad++; $display("FAIL b2b_err_sum: got %0d want %0d", err_sum_o, exp_esum()); end
        if (err_max_o !== exp_max()) begin bad++; $display("FAIL b2b_err_max: got %h want %h", err_max_o, exp_max()); end
    endtask

    task automatic test_backpressure();
        int accepted = 0, got = 0;
        logic held = 1'b0;
        logic [W:0] held_sum = '0;
        logic [W-1:0] pa, pb;
        logic pm;
        exp_t e;
        pa = W'($urandom); pb = W'($urandom); pm = 1'($urandom_range(0, 1));
        for (int c = 0; c < 5; c++) begin
            cycle(1, pa, pb, pm, 0, 0, 0);
            if (in_ready_o) begin
                push_beat(pa, pb, pm);
                accepted++;
                pa = W'($urandom); pb = W'($urandom); pm = 1'($urandom_range(0, 1));
            end
            if (out_valid_o) begin
                if (!held) begin
                    held = 1'b1;
                    held_sum = sum_o;
                end else begin
                    total++;
                    if (sum_o !== held_sum) begin bad++; $display("FAIL bp_stable: got %h want %h", sum_o, held_sum); end
                end
            end
        end
        total += 2;
        if (accepted != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", accepted); end
        if (in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready_o); end
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            cycle(0, 0, 0, 0, 1, 0, 0);
            if (out_valid_o) begin
                e = q.pop_front();
                total++;
                if (sum_o !== e.sum) begin bad++; $display("FAIL bp_sum[%0d]: got %h want %h", got, sum_o, e.sum); end
                model_account(e, 1'b0);
                got++;
            end
        end
        total++;
        if (got != 2) begin bad++; $display("FAIL bp_drain: got %0d want 2", got); end
        q.delete();
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        cycle(1, W'($urandom), W'($urandom), 1, 1, 0, 0);
        cycle(1, W'($urandom), W'($urandom), 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        q.delete();
        model_clear();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cycle(0, 0, 0, 0, 1, 0, 0);
            if (out_valid_o !== 1'b0) seen++;
        end
        total += 5;
        if (seen != 0) begin bad++; $display("FAIL rstmid_valid: got %0d results want 0", seen); end
        if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready_o); end
        if (err_max_o !== '0) begin bad++; $display("FAIL rstmid_err_max: got %h want 0", err_max_o); end
        if (err_sum_o !== '0) begin bad++; $display("FAIL rstmid_err_sum: got %0d want 0", err_sum_o); end
        if (err_cnt_o !== '0) begin bad++; $display("FAIL rstmid_err_cnt: got %0d want 0", err_cnt_o); end
    endtask

    task automatic test_err_clr();
        exp_t e;
        cycle(1, 8'h0F, 8'h01, 1, 1, 0, 0);
        push_beat(8'h0F, 8'h01, 1'b1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        e = q.pop_front();
        model_account(e, 1'b0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        total++;
        if (err_cnt_o !== exp_ecnt()) begin bad++; $display("FAIL clr_pre_cnt: got %0d want %0d", err_cnt_o, exp_ecnt()); end
        cycle(1, 8'h03, 8'h03, 1, 1, 0, 0);
        push_beat(8'h03, 8'h03, 1'b1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 0);
        total += 2;
        if (out_valid_o !== 1'b1) begin bad++; $display("FAIL clr_valid: got %b want 1", out_valid_o); end
        if (sum_o !== 9'h003) begin bad++; $display("FAIL clr_sum: got %h want 003", sum_o); end
        e = q.pop_front();
        model_account(e, 1'b1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        total += 3;
        if (err_sum_o !== (MON ? 32'd3 : 32'd0)) begin bad++; $display("FAIL clr_hs_sum: got %0d want %0d", err_sum_o, MON ? 3 : 0); end
        if (err_cnt_o !== (MON ? 32'd1 : 32'd0)) begin bad++; $display("FAIL clr_hs_cnt: got %0d want %0d", err_cnt_o, MON ? 1 : 0); end
        if (err_max_o !== exp_max()) begin bad++; $display("FAIL clr_hs_max: got %h want %h", err_max_o, exp_max()); end
        cycle(0, 0, 0, 0, 1, 1, 0);
        model_clear();
        cycle(0, 0, 0, 0, 1, 0, 0);
        total += 2;
        if (err_sum_o !== '0) begin bad++; $display("FAIL clr_only_sum: got %0d want 0", err_sum_o); end
        if (err_cnt_o !== '0) begin bad++; $display("FAIL clr_only_cnt: got %0d want 0", err_cnt_o); end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        approx_en_i = 1'b0;
        out_ready_i = 1'b1;
        err_clr_i   = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_err_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/approx_add_pipe.md
APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits, legal range 2..32.
REQ-002 SHALL have parameter APPROX_BITS, default 4, number of low bits computed approximately, legal range 0..WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid_i, input, 1, operand beat valid.
REQ-006 SHALL have port in_ready_o, output, 1, block can accept an operand beat.
REQ-007 SHALL have port a_i, input, WIDTH, operand A (unsigned).
REQ-008 SHALL have port b_i, input, WIDTH, operand B (unsigned).
REQ-009 SHALL have port approx_en_i, input, 1, 1 selects approximate sum and 0 selects exact sum; sampled with the beat.
REQ-010 SHALL have port out_valid_o, output, 1, result valid.
REQ-011 SHALL have port out_ready_i, input, 1, downstream accepts the result.
REQ-012 SHALL have port sum_o, output, WIDTH+1, result including carry-out.
REQ-013 SHALL have port err_clr_i, input, 1, clears the error-monitor counters.
REQ-014 SHALL have port err_max_o, output, WIDTH+1, worst-case absolute error seen.
REQ-015 SHALL have port err_sum_o, output, 32, accumulated absolute error, saturating.
REQ-016 SHALL have port err_cnt_o, output, 32, number of results delivered, saturating.

Function
REQ-017 Approximate sum SHALL be: bits [APPROX_BITS-1:0] = a|b bitwise; upper bits = a[W-1:K]+b[W-1:K]+cin, where cin = a[K-1]&b[K-1] (cin = 0 when K = 0); carry-out goes to sum_o[WIDTH].
REQ-018 Exact sum SHALL be a+b, full WIDTH+1 bits; with APPROX_BITS = 0 both modes are identical.
REQ-019 Datapath SHALL be a two-stage elastic pipeline: S1 registers operands and mode, S2 registers the result; latency is exactly 2 cycles from the input handshake to out_valid_o.
REQ-020 A handshake SHALL occur when valid and ready are both high in the same cycle; a beat is neither dropped nor duplicated.
REQ-021 in_ready_o SHALL equal !S1_full || (S1 advances this cycle); S1 advances when !S2_full || out_ready_i.
REQ-022 With out_ready_i held high, throughput SHALL be one result per cycle.
REQ-023 While out_valid_o is high and out_ready_i is low, sum_o SHALL hold stable.
REQ-024 A simultaneous output handshake and S1 advance SHALL load S2 with the new result in the same edge with no bubble.
REQ-025 in_ready_o SHALL be combinational from out_ready_i and state only, never from in_valid_i.

Reset
REQ-026 rst SHALL empty both stages: out_valid_o = 0, sum_o = 0, err_max_o = 0, err_sum_o = 0, err_cnt_o = 0; in_ready_o = 1 from the first cycle after reset.
REQ-027 rst asserted mid-stream SHALL discard in-flight beats; no result is produced for them.

Configuration
REQ-028 Macro APPROX_ADD_ERR_MON_EN SHALL compile in the error monitor; S2 then also carries the exact sum.
REQ-029 With the monitor: on each output handshake, err = |exact - delivered|; err_max_o = max(err_max_o, err); err_sum_o += err and err_cnt_o += 1, both saturating at 2^32-1.
REQ-030 err_clr_i SHALL zero the counters; if a handshake occurs in the same cycle, the counters SHALL load that handshake's values instead of zero.
REQ-031 Without the macro, err_* ports SHALL remain present and drive constant 0, and no monitor registers SHALL be synthesised.

Structure
REQ-032 Package approx_add_pkg SHALL hold the counter width (32), the saturate constant, and the function for the approximate-sum reference model shared with the bench.
REQ-033 Combinational sub-module approx_add_core (parameters WIDTH and APPROX_BITS; inputs a, b, approx_en; outputs sum, exact_sum) SHALL be instantiated in S1 to S2.

Verification
REQ-034 WIDTH=8, K=4, approx, a=0x0F, b=0x01 -> sum_o=0x00F two cycles after the handshake; exact mode -> 0x010; monitor err=1.
REQ-035 a=0xFF, b=0xFF, approx -> sum_o=0x1FF; exact -> 0x1FE; err_max_o=1.
REQ-036 100 back-to-back beats with out_ready_i=1 -> 100 results in order at one per cycle; err_cnt_o=100.
REQ-037 out_ready_i=0 for 5 cycles while beats arrive -> in_ready_o drops after 2 beats are accepted, sum_o is stable, and there is no loss after release.
REQ-038 rst pulsed with 2 beats in flight -> no out_valid_o for those beats; counters read 0.
REQ-039 err_clr_i coincident with a handshake of err=3 -> err_sum_o=3, err_cnt_o=1.
